// File: rtl/tester_auto_player.sv
// Automatic BlackJack player for FSM benches: watches the game state and hand value and
// drives active-low Hit/Stay buttons with fixed-length presses over a set number of rounds.
module tester_auto_player #(
  parameter int                        NUM_ROUNDS     = 2,
  parameter logic [6*NUM_ROUNDS-1:0]   THRESHOLDS     = {6'd15, 6'd6},
  parameter int                        PRESS_CYCLES   = 255,
  parameter int                        RELEASE_CYCLES = 4,
  parameter int                        MAX_HITS       = 8,
  parameter int                        WAIT_TIMEOUT   = 0,
  parameter logic [4:0]                PLAYER_TURN    = 5'b01001
) (
  input  logic                              clk,
  input  logic                              ResetTester,
  input  logic [4:0]                        StateFSM,
  input  logic [5:0]                        TesterHand,
  output logic                              o_TesterHit,
  output logic                              o_TesterStay,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]   o_Round,
  output logic [$clog2(MAX_HITS+1)-1:0]     o_HitCount,
  output logic                              o_Done,
  output logic                              o_Timeout
);

  localparam int MAXC = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam int RW   = $clog2(NUM_ROUNDS + 1);
  localparam int HW   = $clog2(MAX_HITS + 1);
  localparam int WW   = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  localparam logic [TW-1:0] PRESS_LOAD   = TW'(PRESS_CYCLES - 1);
  localparam logic [TW-1:0] RELEASE_LOAD = TW'(RELEASE_CYCLES - 1);
  localparam logic [RW-1:0] ROUNDS_C     = RW'(NUM_ROUNDS);
  localparam logic [HW-1:0] HITS_C       = HW'(MAX_HITS);
  localparam logic [WW-1:0] TIMEOUT_LAST = WW'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    START      = 3'd0,
    WAIT_TURN  = 3'd1,
    PRESS_HIT  = 3'd2,
    PRESS_STAY = 3'd3,
    RELEASE    = 3'd4,
    DONE       = 3'd5
  } playerState_e;

  playerState_e  stateR, stateN;
  logic [TW-1:0] timerR, timerN;
  logic [RW-1:0] roundR, roundN;
  logic [HW-1:0] hitR, hitN;
  logic [WW-1:0] waitR, waitN;
  logic          armedR, armedN;
  logic          timeoutR, timeoutN;
  logic          isTurnS;

  function automatic logic [5:0] thresholdFor(input logic [RW-1:0] r);
    logic [5:0] t;
    t = THRESHOLDS[5:0];
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      t = (r == RW'(i)) ? THRESHOLDS[6*i +: 6] : t;
    end
    return t;
  endfunction

  assign isTurnS = (StateFSM == PLAYER_TURN);

  // Next-state, counter and timer decisions.
  always_comb begin
    stateN   = stateR;
    timerN   = timerR;
    roundN   = roundR;
    hitN     = hitR;
    waitN    = waitR;
    timeoutN = timeoutR;
    // Re-arm whenever the game leaves the player turn, whatever our own state.
    if (!isTurnS) begin
      armedN = 1'b1;
    end else begin
      armedN = armedR;
    end
    case (stateR)
      START: begin
        stateN = WAIT_TURN;
      end
      WAIT_TURN: begin
        if (isTurnS && armedR) begin
          waitN  = '0;
          armedN = 1'b0;
          timerN = PRESS_LOAD;
          if (hitR == HITS_C) begin
            stateN = PRESS_STAY;
          end else if (TesterHand < thresholdFor(roundR)) begin
            stateN = PRESS_HIT;
          end else begin
            stateN = PRESS_STAY;
          end
        end else if ((WAIT_TIMEOUT != 0) && (waitR == TIMEOUT_LAST)) begin
          waitN    = '0;
          timeoutN = 1'b1;
          stateN   = DONE;
        end else begin
          waitN = waitR + 1'b1;
        end
      end
      PRESS_HIT: begin
        if (timerR == '0) begin
          if (hitR != HITS_C) begin
            hitN = hitR + 1'b1;
          end else begin
            hitN = hitR;
          end
          timerN = RELEASE_LOAD;
          stateN = RELEASE;
        end else begin
          timerN = timerR - 1'b1;
        end
      end
      PRESS_STAY: begin
        if (timerR == '0) begin
          hitN = '0;
          if (roundR != ROUNDS_C) begin
            roundN = roundR + 1'b1;
          end else begin
            roundN = roundR;
          end
          if (roundN == ROUNDS_C) begin
            stateN = DONE;
          end else begin
            timerN = RELEASE_LOAD;
            stateN = RELEASE;
          end
        end else begin
          timerN = timerR - 1'b1;
        end
      end
      RELEASE: begin
        if (timerR == '0) begin
          stateN = WAIT_TURN;
        end else begin
          timerN = timerR - 1'b1;
        end
      end
      DONE: begin
        stateN = DONE;
      end
      default: begin
        stateN = START;
      end
    endcase
  end

  // State, counters and button decode; outputs are registered from the next state.
  always_ff @(posedge clk or posedge ResetTester) begin
    if (ResetTester) begin
      stateR       <= START;
      timerR       <= '0;
      roundR       <= '0;
      hitR         <= '0;
      waitR        <= '0;
      armedR       <= 1'b1;
      timeoutR     <= 1'b0;
      o_TesterHit  <= 1'b1;
      o_TesterStay <= 1'b1;
      o_Done       <= 1'b0;
    end else begin
      stateR       <= stateN;
      timerR       <= timerN;
      roundR       <= roundN;
      hitR         <= hitN;
      waitR        <= waitN;
      armedR       <= armedN;
      timeoutR     <= timeoutN;
      o_TesterHit  <= (stateN != PRESS_HIT);
      o_TesterStay <= (stateN != PRESS_STAY);
      o_Done       <= (stateN == DONE) && !timeoutN;
    end
  end

  assign o_Round    = roundR;
  assign o_HitCount = hitR;
  assign o_Timeout  = timeoutR;

endmodule

// File: tb/tb_tester_auto_player.sv
// Directed bench for tester_auto_player: play, re-arm, round progression, hit cap,
// wait timeout and asynchronous reset in the middle of a press.
module tb_tester_auto_player;

  localparam logic [4:0] PT = 5'b01001;

  logic clk;
  logic rstA, rstB, rstC;
  logic [4:0] stA, stB, stC;
  logic [5:0] handA, handB, handC;

  logic hitA, stayA, doneA, toA;
  logic [1:0] roundA;
  logic [3:0] hcA;
  logic hitB, stayB, doneB, toB;
  logic [1:0] roundB;
  logic [1:0] hcB;
  logic hitC, stayC, doneC, toC;
  logic [1:0] roundC;
  logic [3:0] hcC;

  int passed;
  int total;
  int failed;

  tester_auto_player #(.PRESS_CYCLES(4), .RELEASE_CYCLES(2)) dutA (
    .clk(clk), .ResetTester(rstA), .StateFSM(stA), .TesterHand(handA),
    .o_TesterHit(hitA), .o_TesterStay(stayA), .o_Round(roundA),
    .o_HitCount(hcA), .o_Done(doneA), .o_Timeout(toA));

  tester_auto_player #(.PRESS_CYCLES(4), .RELEASE_CYCLES(2), .MAX_HITS(2)) dutB (
    .clk(clk), .ResetTester(rstB), .StateFSM(stB), .TesterHand(handB),
    .o_TesterHit(hitB), .o_TesterStay(stayB), .o_Round(roundB),
    .o_HitCount(hcB), .o_Done(doneB), .o_Timeout(toB));

  tester_auto_player #(.PRESS_CYCLES(4), .RELEASE_CYCLES(2), .WAIT_TIMEOUT(10)) dutC (
    .clk(clk), .ResetTester(rstC), .StateFSM(stC), .TesterHand(handC),
    .o_TesterHit(hitC), .o_TesterStay(stayC), .o_Round(roundC),
    .o_HitCount(hcC), .o_Done(doneC), .o_Timeout(toC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    passed = 0; total = 0; failed = 0;
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    stA = 5'd0; stB = 5'd0; stC = 5'd0;
    handA = 6'd0; handB = 6'd0; handC = 6'd0;
    tick(2);

    check("rst hit", {31'd0, hitA}, 32'd1);
    check("rst stay", {31'd0, stayA}, 32'd1);
    check("rst round", {30'd0, roundA}, 32'd0);
    check("rst hitcount", {28'd0, hcA}, 32'd0);
    check("rst done", {31'd0, doneA}, 32'd0);
    check("rst timeout", {31'd0, toA}, 32'd0);

    // Low hand in round 0 -> Hit for 4 cycles, then 2 release cycles.
    stA = PT; handA = 6'd3; rstA = 1'b0;
    tick(1);
    check("A start no press", {31'd0, hitA}, 32'd1);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check("A hit low", {31'd0, hitA}, 32'd0);
      check("A stay high in hit", {31'd0, stayA}, 32'd1);
      tick(1);
    end
    check("A hit released", {31'd0, hitA}, 32'd1);
    check("A hitcount 1", {28'd0, hcA}, 32'd1);
    tick(1);
    check("A release 2 hit", {31'd0, hitA}, 32'd1);
    check("A release 2 stay", {31'd0, stayA}, 32'd1);

    // StateFSM held at player turn: no re-arm, no second press.
    tick(5);
    check("A no rearm hit", {31'd0, hitA}, 32'd1);
    check("A no rearm count", {28'd0, hcA}, 32'd1);

    stA = 5'd0; tick(1); stA = PT; tick(1);
    check("A rearm hit low", {31'd0, hitA}, 32'd0);
    tick(4);
    check("A rearm hit released", {31'd0, hitA}, 32'd1);
    check("A hitcount 2", {28'd0, hcA}, 32'd2);

    // Round 0, hand 10 >= 6 -> Stay; hand change mid-press is ignored.
    tick(2);
    handA = 6'd10; stA = 5'd0; tick(1); stA = PT; tick(1);
    check("A stay low r0", {31'd0, stayA}, 32'd0);
    check("A hit high r0 stay", {31'd0, hitA}, 32'd1);
    handA = 6'd0;
    tick(3);
    check("A stay held", {31'd0, stayA}, 32'd0);
    tick(1);
    check("A stay released", {31'd0, stayA}, 32'd1);
    check("A round 1", {30'd0, roundA}, 32'd1);
    check("A hitcount cleared", {28'd0, hcA}, 32'd0);

    // Round 1 threshold 15: 14 hits, 15 stays.
    tick(2);
    handA = 6'd14; stA = 5'd0; tick(1); stA = PT; tick(1);
    check("A r1 hit low", {31'd0, hitA}, 32'd0);
    tick(4);
    check("A r1 hitcount", {28'd0, hcA}, 32'd1);
    tick(2);
    handA = 6'd15; stA = 5'd0; tick(1); stA = PT; tick(1);
    check("A r1 stay low", {31'd0, stayA}, 32'd0);
    check("A r1 hit high", {31'd0, hitA}, 32'd1);
    tick(4);
    check("A final stay released", {31'd0, stayA}, 32'd1);
    check("A round 2", {30'd0, roundA}, 32'd2);
    check("A done", {31'd0, doneA}, 32'd1);
    check("A done hitcount", {28'd0, hcA}, 32'd0);
    check("A no timeout", {31'd0, toA}, 32'd0);
    stA = 5'd0; tick(1); stA = PT; tick(3);
    check("A done hit high", {31'd0, hitA}, 32'd1);
    check("A done stay high", {31'd0, stayA}, 32'd1);
    check("A done held", {31'd0, doneA}, 32'd1);
    check("A round held", {30'd0, roundA}, 32'd2);

    // Reset mid-press while a second hit is held low.
    rstA = 1'b1; handA = 6'd3; tick(1);
    check("A rerst done clear", {31'd0, doneA}, 32'd0);
    rstA = 1'b0; tick(2);
    check("A replay hit low", {31'd0, hitA}, 32'd0);
    tick(4);
    tick(2);
    stA = 5'd0; tick(1); stA = PT; tick(1);
    tick(1);
    check("A pre-reset hit low", {31'd0, hitA}, 32'd0);
    check("A pre-reset count", {28'd0, hcA}, 32'd1);
    #3 rstA = 1'b1;
    #1;
    check("A async rst hit", {31'd0, hitA}, 32'd1);
    check("A async rst count", {28'd0, hcA}, 32'd0);
    check("A async rst round", {30'd0, roundA}, 32'd0);
    rstA = 1'b0;
    tick(1);
    check("A post rst start", {31'd0, hitA}, 32'd1);
    tick(1);
    check("A resume hit low", {31'd0, hitA}, 32'd0);
    tick(4);
    check("A resume hitcount", {28'd0, hcA}, 32'd1);

    // Hit cap of 2 with hand 0: two hits, then a forced stay.
    stB = PT; handB = 6'd0; rstB = 1'b0;
    tick(2);
    check("B hit1 low", {31'd0, hitB}, 32'd0);
    tick(4);
    check("B hitcount 1", {30'd0, hcB}, 32'd1);
    tick(2);
    stB = 5'd0; tick(1); stB = PT; tick(1);
    check("B hit2 low", {31'd0, hitB}, 32'd0);
    tick(4);
    check("B hitcount 2", {30'd0, hcB}, 32'd2);
    tick(2);
    stB = 5'd0; tick(1); stB = PT; tick(1);
    check("B forced stay low", {31'd0, stayB}, 32'd0);
    check("B forced stay hit high", {31'd0, hitB}, 32'd1);
    tick(4);
    check("B stay released", {31'd0, stayB}, 32'd1);
    check("B hitcount cleared", {30'd0, hcB}, 32'd0);
    check("B round 1", {30'd0, roundB}, 32'd1);
    check("B not done", {31'd0, doneB}, 32'd0);

    // Wait timeout of 10 with the player turn never reached.
    rstC = 1'b0;
    tick(10);
    check("C before timeout", {31'd0, toC}, 32'd0);
    check("C before timeout done", {31'd0, doneC}, 32'd0);
    tick(1);
    check("C timeout", {31'd0, toC}, 32'd1);
    check("C timeout not done", {31'd0, doneC}, 32'd0);
    check("C timeout hit high", {31'd0, hitC}, 32'd1);
    check("C timeout stay high", {31'd0, stayC}, 32'd1);
    tick(5);
    check("C timeout held", {31'd0, toC}, 32'd1);
    check("C still not done", {31'd0, doneC}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
